csit_luks_encoder_if: RTL and testbench

//  Tiny Tapeout top for a rotary-encoder user interface. Decodes a quadrature

---
 rtl/csit_luks_pkg.sv | 10 +
 rtl/csit_luks_encoder_if_quad_decoder.sv | 18 +
 rtl/csit_luks_encoder_if.sv | 85 ++++++++
 tb/tb_csit_luks_encoder_if.sv | 122 ++++++++++++
 4 files changed

// File: rtl/csit_luks_pkg.sv
// csit_luks_pkg: shared types and constants for the rotary-encoder user interface
package csit_luks_pkg;
  typedef enum logic [1:0] {PB_NONE = 2'd0, PB_SHORT = 2'd1, PB_LONG = 2'd2} press_type_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_HELD = 1'b1} press_state_e;
  localparam logic [7:0] UIO_OE_MASK = 8'h07;
  // Map the {B,A} Gray state onto a linear 0..3 position so a CW step is +1 mod 4
  function automatic logic [1:0] quad_pos(input logic [1:0] ba);
    return {ba[1], ba[1] ^ ba[0]};
  endfunction
endpackage

// File: rtl/csit_luks_encoder_if_quad_decoder.sv
// quad_decoder: x4 quadrature decoder producing single-cycle inc/dec pulses
module quad_decoder
  import csit_luks_pkg::*;
(
  input  logic clk,
  input  logic a_i,
  input  logic b_i,
  output logic inc_o,
  output logic dec_o
);
  logic [1:0] prev_q;
  logic [1:0] step;
  // Previous state always follows the input, so reset and illegal jumps both resync it
  always_ff @(posedge clk) prev_q <= {b_i, a_i};
  assign step  = quad_pos({b_i, a_i}) - quad_pos(prev_q);
  assign inc_o = step == 2'd1;
  assign dec_o = step == 2'd3;
endmodule

// File: rtl/csit_luks_encoder_if.sv
// csit_luks_encoder_if: encoder position counter plus short/long pushbutton classifier
module csit_luks_encoder_if
  import csit_luks_pkg::*;
#(
  parameter logic [7:0] CNT_INIT     = 8'd9,
  parameter int         DEBOUNCE_CYC = 16,
  parameter int         LONG_CYC     = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(LONG_CYC + 1);
  logic          rst;
  logic [2:0]    s1_q, s2_q;
  logic          inc, dec;
  logic [7:0]    count_q;
  logic [DW-1:0] stab_q;
  logic          pb_q;
  press_state_e  state_q;
  logic [HW-1:0] hold_q;
  press_type_e   type_q;
  logic          done_q;
  logic          unused_in;
  // The reset pin is named rst_n but is asserted high
  assign rst = rst_n;
  assign unused_in = &{1'b0, ena, uio_in, ui_in[7:3]};
  // Two-flop synchronizer for encoder A/B and the pushbutton
  always_ff @(posedge clk) begin
    s1_q <= ui_in[2:0];
    s2_q <= s1_q;
  end
  quad_decoder u_quad (
    .clk  (clk),
    .a_i  (s2_q[0]),
    .b_i  (s2_q[1]),
    .inc_o(inc),
    .dec_o(dec)
  );
  // Position counter, wraps modulo 256
  always_ff @(posedge clk)
    if (rst) count_q <= CNT_INIT;
    else if (inc) count_q <= count_q + 8'd1;
    else if (dec) count_q <= count_q - 8'd1;
  // Debounce: the raw level must disagree for DEBOUNCE_CYC straight cycles to be accepted
  always_ff @(posedge clk)
    if (rst) begin
      pb_q   <= 1'b1;
      stab_q <= '0;
    end else if (s2_q[2] != pb_q) begin
      if (stab_q == DW'(DEBOUNCE_CYC - 1)) begin
        pb_q   <= s2_q[2];
        stab_q <= '0;
      end else stab_q <= stab_q + 1'b1;
    end else stab_q <= '0;
  // Press FSM: time the debounced hold and classify it on release
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      type_q  <= PB_NONE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (!pb_q) begin
          state_q <= ST_HELD;
          hold_q  <= '0;
        end
      end else if (pb_q) begin
        state_q <= ST_IDLE;
        type_q  <= hold_q >= HW'(LONG_CYC) ? PB_LONG : PB_SHORT;
        done_q  <= 1'b1;
      end else if (hold_q != HW'(LONG_CYC)) hold_q <= hold_q + 1'b1;
    end
  assign uo_out  = count_q;
  assign uio_out = {5'b0, done_q, type_q};
  assign uio_oe  = UIO_OE_MASK;
endmodule

// File: tb/tb_csit_luks_encoder_if.sv
// tb_csit_luks_encoder_if: directed stimulus against a cycle model of the encoder UI
module tb_csit_luks_encoder_if;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  int errors = 0;
  int checks = 0;
  int strobes = 0;

  csit_luks_encoder_if dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  // Model state: pins seen through two sync stages, position from the Gray sequence,
  // button as a debounced level feeding a press timer
  int       pos_tbl[4] = '{0, 1, 3, 2};
  bit [2:0] m_s1, m_s2, old;
  bit [1:0] m_prev;
  bit [7:0] m_cnt;
  bit       m_deb, m_held, m_done;
  int       m_stab, m_hold, m_type, d;

  always @(posedge clk) begin
    old = m_s2;
    if (rst_n) begin
      m_cnt = 8'd9; m_prev = old[1:0]; m_deb = 1; m_stab = 0;
      m_held = 0; m_hold = 0; m_type = 0; m_done = 0;
    end else begin
      d = (pos_tbl[old[1:0]] - pos_tbl[m_prev] + 4) % 4;
      if (d == 1) m_cnt = m_cnt + 8'd1;
      else if (d == 3) m_cnt = m_cnt - 8'd1;
      m_prev = old[1:0];
      m_done = 0;
      if (m_held && m_deb) begin
        m_held = 0; m_type = (m_hold >= 500) ? 2 : 1; m_done = 1;
      end else if (!m_held && !m_deb) begin
        m_held = 1; m_hold = 0;
      end else if (m_held && m_hold < 500) m_hold++;
      if (old[2] != m_deb) begin
        m_stab++;
        if (m_stab == 16) begin m_deb = old[2]; m_stab = 0; end
      end else m_stab = 0;
    end
    m_s2 = m_s1;
    m_s1 = ui_in[2:0];
  end

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance n cycles, comparing DUT against the model 2 ns after each edge
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      lit("model_count", uo_out, m_cnt);
      lit("model_uio", uio_out, {5'b0, m_done, m_type[1:0]});
      if (uio_out[2]) strobes++;
    end
  endtask

  int ab3[7]  = '{3, 1, 0, 2, 3, 1, 0};
  int ex3[7]  = '{11, 10, 9, 8, 7, 6, 5};
  int ab6[10] = '{2, 3, 1, 0, 2, 3, 2, 0, 3, 2};
  int ex6[10] = '{4, 3, 2, 1, 0, 255, 0, 1, 1, 2};
  int s0;

  initial begin
    ena = 1'b1; uio_in = 8'h00; ui_in = 8'b0000_0100; rst_n = 1'b1;
    cyc(10);
    lit("reset_count", uo_out, 9);
    lit("reset_type", uio_out[1:0], 0);
    lit("uio_oe", uio_oe, 8'h07);
    rst_n = 1'b0;
    ui_in[1:0] = 2'b01; cyc(100); lit("cw_1", uo_out, 10);
    ui_in[1:0] = 2'b11; cyc(100); lit("cw_2", uo_out, 11);
    ui_in[1:0] = 2'b10; cyc(100); lit("cw_3", uo_out, 12);
    for (int i = 0; i < 7; i++) begin
      ui_in[1:0] = 2'(ab3[i]); cyc(20); lit("ccw_seq", uo_out, ex3[i]);
    end
    ui_in[2] = 1'b0; cyc(100); ui_in[2] = 1'b1; cyc(100);
    lit("short_strobes", strobes, 1);
    lit("short_type", uio_out[1:0], 1);
    ui_in[2] = 1'b0; cyc(5); ui_in[2] = 1'b1; cyc(50);
    lit("glitch_strobes", strobes, 1);
    lit("glitch_type", uio_out[1:0], 1);
    ui_in[2] = 1'b0; cyc(600); ui_in[2] = 1'b1; cyc(100);
    lit("long_strobes", strobes, 2);
    lit("long_type", uio_out[1:0], 2);
    for (int i = 0; i < 10; i++) begin
      ui_in[1:0] = 2'(ab6[i]); cyc(20); lit("wrap_illegal", uo_out, ex6[i]);
    end
    s0 = strobes;
    ui_in[2] = 1'b0; cyc(300);
    rst_n = 1'b1; cyc(3); rst_n = 1'b0; cyc(1);
    lit("midpress_type", uio_out[1:0], 0);
    lit("midpress_count", uo_out, 9);
    lit("midpress_strobes", strobes, s0);
    ui_in[2] = 1'b1; ui_in[1:0] = 2'b11; cyc(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
